// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared definitions for the multiply/divide engine:
//                md_op encodings (same ordering as the core's opcode set),
//                FSM state encoding, default latency constants and the
//                operand-magnitude helper.
//  Config      : MD_FAST_MULT_EN (used by md_engine, not by this package)
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // md_op encodings
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Default latencies
    localparam int DEF_DIV_ITERS    = 32;
    localparam int DEF_FAST_MUL_LAT = 5;

    // Magnitude of a 32-bit operand; only negates when the op is signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter_core
//  Description : Iterative datapath shared by multiply and divide.
//                A 64-bit accumulator plus a 32-bit operand register; each
//                step performs one radix-2 shift-add (multiply) or one
//                restoring shift-subtract (divide).
//  Ports       : clk, reset (async, active-low)
//                load      - initialise acc={0,init_lo}, opnd, counter=0
//                step      - advance one iteration
//                is_div    - 1: divide step, 0: multiply step
//                init_lo   - multiplier / dividend magnitude
//                init_opnd - multiplicand / divisor magnitude
//                acc       - {hi,lo} product or {remainder,quotient}
//                last      - counter is on its final iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module md_iter_core
    import md_pkg::*;
#(
    parameter int DIV_ITERS = DEF_DIV_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] init_lo,
    input  logic [31:0] init_opnd,
    output logic [63:0] acc,
    output logic        last
);

    localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

    logic [31:0]   opnd;
    logic [CW-1:0] cnt;
    logic [63:0]   acc_next;
    logic [32:0]   add_sum;
    logic [32:0]   rem_ext;
    logic [33:0]   diff;

    always_comb begin
        acc_next = acc;
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the 65-bit result right.
        add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        // Divide: shift in the next dividend bit; the partial remainder can
        // briefly need 33 bits before the trial subtraction.
        rem_ext  = acc[63:31];
        diff     = {1'b0, rem_ext} - {2'b00, opnd};
        if (is_div) begin
            if (!diff[33]) begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {rem_ext[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc[31:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= 64'd0;
            opnd <= 32'd0;
            cnt  <= '0;
        end else if (load) begin
            acc  <= {32'd0, init_lo};
            opnd <= init_opnd;
            cnt  <= '0;
        end else if (step) begin
            acc  <= acc_next;
            cnt  <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(DIV_ITERS - 1));

endmodule
`default_nettype wire

// File: rtl/md_engine.sv
`default_nettype none
// ============================================================================
//  Module      : md_engine
//  Description : Multi-cycle multiply/divide unit holding HI/LO.
//                IDLE accepts one op per start pulse; arithmetic ops run
//                DIV_ITERS iterations (RUN) then one sign-fix/commit cycle
//                (FIX). MTHI/MTLO write immediately with no busy cycles.
//  Config      : MD_FAST_MULT_EN - MULT/MULTU use a single-cycle product
//                held for FAST_MUL_LAT busy cycles before committing.
//  Ports       : clk, reset (async, active-low), start, md_op[2:0],
//                a[31:0], b[31:0] -> busy, hi[31:0], lo[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module md_engine
    import md_pkg::*;
#(
    parameter int DIV_ITERS    = DEF_DIV_ITERS,
    parameter int FAST_MUL_LAT = DEF_FAST_MUL_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e state, next_state;

    logic        accept;
    logic        arith;
    logic        op_signed;
    logic        core_last;
    logic [63:0] core_acc;

    logic        op_div;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;

    logic        commit;
    logic [31:0] commit_hi;
    logic [31:0] commit_lo;
    logic [63:0] mul_res;
    logic        core_step;

    assign accept    = (state == ST_IDLE) && start;
    assign arith     = accept && !md_op[2];
    assign op_signed = !md_op[0];

`ifdef MD_FAST_MULT_EN
    localparam int FW = (FAST_MUL_LAT > 1) ? $clog2(FAST_MUL_LAT) : 1;
    logic          fast;
    logic [FW-1:0] fcnt;
    logic [63:0]   prod;
    logic          fast_done;

    assign fast_done = (state == ST_RUN) && fast && (fcnt == '0);
    assign core_step = (state == ST_RUN) && !fast;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fast <= 1'b0;
            fcnt <= '0;
            prod <= 64'd0;
        end else if (arith) begin
            fast <= !md_op[1];
            fcnt <= FW'(FAST_MUL_LAT - 1);
            prod <= md_op[0] ? ({32'd0, a} * {32'd0, b})
                             : 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        end else if ((state == ST_RUN) && fast) begin
            fcnt <= fcnt - FW'(1);
        end
    end
`else
    wire unused_fast_lat = |FAST_MUL_LAT;
    assign core_step = (state == ST_RUN);
`endif

    md_iter_core #(
        .DIV_ITERS (DIV_ITERS)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (arith),
        .step      (core_step),
        .is_div    (op_div),
        .init_lo   (mag32(a, op_signed)),
        .init_opnd (mag32(b, op_signed)),
        .acc       (core_acc),
        .last      (core_last)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (arith) next_state = ST_RUN;
            ST_RUN: begin
`ifdef MD_FAST_MULT_EN
                if (fast) begin
                    if (fcnt == '0) next_state = ST_IDLE;
                end else if (core_last) begin
                    next_state = ST_FIX;
                end
`else
                if (core_last) next_state = ST_FIX;
`endif
            end
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Sign correction and commit selection
    always_comb begin
        mul_res   = q_neg ? (64'd0 - core_acc) : core_acc;
        commit    = 1'b0;
        commit_hi = hi;
        commit_lo = lo;
        if (state == ST_FIX) begin
            if (op_div) begin
                // A zero divisor leaves HI/LO untouched.
                commit    = !div_zero;
                commit_lo = q_neg ? (32'd0 - core_acc[31:0])  : core_acc[31:0];
                commit_hi = r_neg ? (32'd0 - core_acc[63:32]) : core_acc[63:32];
            end else begin
                commit    = 1'b1;
                commit_hi = mul_res[63:32];
                commit_lo = mul_res[31:0];
            end
        end
`ifdef MD_FAST_MULT_EN
        if (fast_done) begin
            commit    = 1'b1;
            commit_hi = prod[63:32];
            commit_lo = prod[31:0];
        end
`endif
    end

    // Operation flags, busy and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_div   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            busy <= (next_state != ST_IDLE);
            if (arith) begin
                op_div   <= md_op[1];
                q_neg    <= op_signed && (a[31] ^ b[31]);
                r_neg    <= op_signed && a[31];
                div_zero <= (b == 32'd0);
            end
            if (accept && (md_op == MD_MTHI)) hi <= a;
            if (accept && (md_op == MD_MTLO)) lo <= a;
            if (commit) begin
                hi <= commit_hi;
                lo <= commit_lo;
            end
        end
    end

endmodule
`default_nettype wire
